// File: rtl/ras.sv
// Return address stack for the fetch predictor: circular 8-entry stack of PC[31:1]
// return targets with checkpointable pointer/occupancy for mispredict recovery.
module ras #(
    parameter int RAS_ENTRIES      = 8,
    parameter int RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        push_valid,
    input  logic [RAS_TARGET_WIDTH-1:0] push_target,
    input  logic                        pop_valid,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count,
    output logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count
);

    localparam logic [RAS_INDEX_WIDTH:0]   FULL_COUNT = (RAS_INDEX_WIDTH + 1)'(RAS_ENTRIES);
    localparam logic [RAS_INDEX_WIDTH-1:0] INDEX_ONE  = RAS_INDEX_WIDTH'(1);
    localparam logic [RAS_INDEX_WIDTH:0]   COUNT_ONE  = (RAS_INDEX_WIDTH + 1)'(1);

    logic [RAS_INDEX_WIDTH-1:0]  ptr;
    logic [RAS_INDEX_WIDTH-1:0]  top_index;
    logic [RAS_INDEX_WIDTH:0]    count;
    logic [RAS_TARGET_WIDTH-1:0] stack [RAS_ENTRIES];
    logic                        empty;
    logic                        push_only;
    logic                        swap;
    logic                        pop_only;

    assign top_index = ptr - INDEX_ONE;
    assign empty     = (count == '0);

    // A push+pop on an empty stack has nothing to replace, so it degrades to a plain push.
    assign push_only = push_valid && (!pop_valid || empty);
    assign swap      = push_valid && pop_valid && !empty;
    assign pop_only  = pop_valid && !push_valid && !empty;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack[i] <= '0;
            end
        end else if (restore_valid) begin
            ptr   <= restore_index;
            count <= restore_count;
        end else if (push_only) begin
            stack[ptr] <= push_target;
            ptr        <= ptr + INDEX_ONE;
            if (count != FULL_COUNT) begin
                count <= count + COUNT_ONE;
            end
        end else if (swap) begin
            stack[top_index] <= push_target;
        end else if (pop_only) begin
            ptr   <= top_index;
            count <= count - COUNT_ONE;
        end
    end

    assign ret_valid  = !empty;
    assign ret_target = stack[top_index];
    assign ras_index  = ptr;
    assign ras_count  = count;

    // A checkpoint can never hold more entries than the stack has slots.
    restore_count_legal: assert property (@(posedge CLK) disable iff (!nRST)
        restore_valid |-> (restore_count <= FULL_COUNT));

endmodule

// File: tb/tb_ras.sv
// Self-checking bench for ras: directed scenarios plus a randomized phase, all
// checked against a behavioural circular-stack model held in the bench.
module tb_ras;

    localparam int ENTRIES = 8;

    logic        CLK;
    logic        nRST;
    logic        push_valid;
    logic [30:0] push_target;
    logic        pop_valid;
    logic        restore_valid;
    logic [2:0]  restore_index;
    logic [3:0]  restore_count;
    logic        ret_valid;
    logic [30:0] ret_target;
    logic [2:0]  ras_index;
    logic [3:0]  ras_count;

    int vectors;
    int miscompares;

    int          m_ptr;
    int          m_cnt;
    logic [30:0] m_stack [ENTRIES];

    ras dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .push_valid    (push_valid),
        .push_target   (push_target),
        .pop_valid     (pop_valid),
        .restore_valid (restore_valid),
        .restore_index (restore_index),
        .restore_count (restore_count),
        .ret_valid     (ret_valid),
        .ret_target    (ret_target),
        .ras_index     (ras_index),
        .ras_count     (ras_count)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < ENTRIES; i++) m_stack[i] = '0;
    endtask

    // Reference behaviour: restore wins; push+pop on a non-empty stack replaces the top.
    task automatic modelStep(input bit psh, input logic [30:0] tgt, input bit pp,
                             input bit rv, input int ri, input int rc);
        if (rv) begin
            m_ptr = ri;
            m_cnt = rc;
        end else if (psh && pp && m_cnt > 0) begin
            m_stack[(m_ptr + ENTRIES - 1) % ENTRIES] = tgt;
        end else if (psh) begin
            m_stack[m_ptr] = tgt;
            m_ptr = (m_ptr + 1) % ENTRIES;
            m_cnt = (m_cnt < ENTRIES) ? m_cnt + 1 : ENTRIES;
        end else if (pp && m_cnt > 0) begin
            m_ptr = (m_ptr + ENTRIES - 1) % ENTRIES;
            m_cnt = m_cnt - 1;
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".valid"},  32'(ret_valid),  32'(m_cnt != 0));
        checkVal({tag, ".target"}, 32'(ret_target), 32'(m_stack[(m_ptr + ENTRIES - 1) % ENTRIES]));
        checkVal({tag, ".index"},  32'(ras_index),  32'(m_ptr));
        checkVal({tag, ".count"},  32'(ras_count),  32'(m_cnt));
    endtask

    task automatic applyStimulus(input string tag, input bit psh, input logic [30:0] tgt,
                                 input bit pp, input bit rv, input int ri, input int rc);
        push_valid    = psh;
        push_target   = tgt;
        pop_valid     = pp;
        restore_valid = rv;
        restore_index = 3'(ri);
        restore_count = 4'(rc);
        @(posedge CLK);
        modelStep(psh, tgt, pp, rv, ri, rc);
        #1;
        push_valid    = 1'b0;
        push_target   = '0;
        pop_valid     = 1'b0;
        restore_valid = 1'b0;
        restore_index = '0;
        restore_count = '0;
        checkOutput(tag);
    endtask

    task automatic checkState(input string tag, input int idx, input int cnt, input logic [30:0] tgt);
        checkVal({tag, ".dir_index"},  32'(ras_index),  32'(idx));
        checkVal({tag, ".dir_count"},  32'(ras_count),  32'(cnt));
        checkVal({tag, ".dir_target"}, 32'(ret_target), 32'(tgt));
    endtask

    initial begin
        CLK           = 1'b0;
        nRST          = 1'b0;
        push_valid    = 1'b0;
        push_target   = '0;
        pop_valid     = 1'b0;
        restore_valid = 1'b0;
        restore_index = '0;
        restore_count = '0;
        vectors       = 0;
        miscompares   = 0;
        modelReset();

        #12;
        checkVal("reset.valid", 32'(ret_valid), 32'd0);
        checkState("reset", 0, 0, 31'h0);
        @(negedge CLK);
        nRST = 1'b1;

        $display("[TB] idle and pop on empty");
        applyStimulus("idle", 0, 31'h0, 0, 0, 0, 0);
        applyStimulus("pop_empty", 0, 31'h0, 1, 0, 0, 0);
        checkState("pop_empty", 0, 0, 31'h0);
        checkVal("pop_empty.valid", 32'(ret_valid), 32'd0);

        $display("[TB] basic push/pop");
        applyStimulus("push1", 1, 31'h1000, 0, 0, 0, 0);
        applyStimulus("push2", 1, 31'h2000, 0, 0, 0, 0);
        applyStimulus("push3", 1, 31'h3000, 0, 0, 0, 0);
        checkState("push3", 3, 3, 31'h3000);
        applyStimulus("pop1", 0, 31'h0, 1, 0, 0, 0);
        applyStimulus("pop2", 0, 31'h0, 1, 0, 0, 0);
        checkState("pop2", 1, 1, 31'h1000);
        applyStimulus("drain", 0, 31'h0, 1, 0, 0, 0);

        $display("[TB] overflow and wrap");
        for (int i = 1; i <= 10; i++) applyStimulus("ovf_push", 1, 31'(i), 0, 0, 0, 0);
        checkState("ovf", 2, 8, 31'hA);
        for (int i = 0; i < 8; i++) begin
            checkVal("ovf_top", 32'(ret_target), 32'(10 - i));
            applyStimulus("ovf_pop", 0, 31'h0, 1, 0, 0, 0);
        end
        checkVal("ovf_empty.valid", 32'(ret_valid), 32'd0);
        checkVal("ovf_empty.count", 32'(ras_count), 32'd0);
        checkVal("ovf_empty.index", 32'(ras_index), 32'd2);

        $display("[TB] push+pop swap");
        applyStimulus("rst_ptr", 0, 31'h0, 0, 1, 0, 0);
        applyStimulus("swap_push", 1, 31'h40, 0, 0, 0, 0);
        applyStimulus("swap", 1, 31'h50, 1, 0, 0, 0);
        checkState("swap", 1, 1, 31'h50);
        applyStimulus("swap_pop", 0, 31'h0, 1, 0, 0, 0);
        applyStimulus("swap_empty", 1, 31'h60, 1, 0, 0, 0);
        checkState("swap_empty", 1, 1, 31'h60);

        $display("[TB] checkpoint restore");
        applyStimulus("ckpt_pop", 0, 31'h0, 1, 0, 0, 0);
        applyStimulus("ckpt_push1", 1, 31'h11, 0, 0, 0, 0);
        applyStimulus("ckpt_push2", 1, 31'h22, 0, 0, 0, 0);
        checkState("ckpt_capture", 2, 2, 31'h22);
        applyStimulus("ckpt_push3", 1, 31'h33, 0, 0, 0, 0);
        applyStimulus("ckpt_pop1", 0, 31'h0, 1, 0, 0, 0);
        applyStimulus("ckpt_pop2", 0, 31'h0, 1, 0, 0, 0);
        applyStimulus("restore", 1, 31'h77, 0, 1, 2, 2);
        checkState("restore", 2, 2, 31'h22);

        $display("[TB] asynchronous reset");
        applyStimulus("pre_reset", 1, 31'hAA, 0, 0, 0, 0);
        #2;
        nRST = 1'b0;
        #1;
        modelReset();
        checkVal("async_reset.valid", 32'(ret_valid), 32'd0);
        checkState("async_reset", 0, 0, 31'h0);
        @(negedge CLK);
        nRST = 1'b1;
        applyStimulus("post_reset", 1, 31'hBB, 0, 0, 0, 0);
        checkState("post_reset", 1, 1, 31'hBB);

        $display("[TB] randomized phase");
        for (int n = 0; n < 400; n++) begin
            bit          psh;
            bit          pp;
            bit          rv;
            logic [30:0] tgt;
            psh = 1'($urandom);
            pp  = 1'($urandom);
            rv  = ($urandom_range(0, 11) == 0);
            tgt = 31'($urandom);
            applyStimulus("random", psh, tgt, pp, rv,
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 8)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
